// File: rtl/sprite_loader.sv
// Serial 1-bit sprite bitmap loader with a registered scan-position read port.
// Optional macro SPRITE_MIRROR_EN adds a 'mirror' input for horizontal flipping.
module sprite_loader #(
  parameter int SPR_W = 87,
  parameter int SPR_H = 86
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic        busy,
  output logic        load_done,
  output logic        loaded,
  input  logic [10:0] col,
  input  logic [10:0] row,
  input  logic [10:0] b_col,
  input  logic [10:0] b_row,
`ifdef SPRITE_MIRROR_EN
  input  logic        mirror,
`endif
  output logic        pixel
);

  localparam int DEPTH  = SPR_W * SPR_H;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WX_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int WY_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [WX_W-1:0] WX_LAST = WX_W'(SPR_W - 1);
  localparam logic [WY_W-1:0] WY_LAST = WY_W'(SPR_H - 1);
  localparam logic [10:0]     W11     = 11'(SPR_W);
  localparam logic [10:0]     H11     = 11'(SPR_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [WX_W-1:0]   wx_reg;
  logic [WY_W-1:0]   wy_reg;
  logic              loaded_reg;
  logic              pixel_reg;

  logic              accept;
  logic              last_bit;
  logic [ADDR_W-1:0] wr_addr;

  logic [10:0]       dx;
  logic [10:0]       dy;
  logic [10:0]       rd_col;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  logic              mem [0:DEPTH-1];

  assign accept   = (state_reg == LOAD) && bit_valid;
  assign last_bit = accept && (wx_reg == WX_LAST) && (wy_reg == WY_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_start) state_next = LOAD;
      LOAD:    if (last_bit)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bit_ready = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state_reg)
      LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wx_reg <= '0;
      wy_reg <= '0;
    end else if ((state_reg == IDLE) && load_start) begin
      wx_reg <= '0;
      wy_reg <= '0;
    end else if (accept) begin
      if (wx_reg == WX_LAST) begin
        wx_reg <= '0;
        wy_reg <= wy_reg + 1'b1;
      end else begin
        wx_reg <= wx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_reg <= 1'b0;
    end else if ((state_reg == IDLE) && load_start) begin
      loaded_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      loaded_reg <= 1'b1;
    end
  end

  assign loaded = loaded_reg;

  assign wr_addr = ADDR_W'(wy_reg) * ADDR_W'(SPR_W) + ADDR_W'(wx_reg);

  // Offsets wrap when the scan is left of / above the sprite, so one
  // unsigned compare per axis covers both sides of the bound.
  assign dx    = col - b_col;
  assign dy    = row - b_row;
  assign rd_en = loaded_reg && (dx < W11) && (dy < H11);

`ifdef SPRITE_MIRROR_EN
  assign rd_col = mirror ? (W11 - 11'd1 - dx) : dx;
`else
  assign rd_col = dx;
`endif

  assign rd_addr = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(rd_col);

  // Contents are never cleared; loaded_reg masks stale data instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_reg <= 1'b0;
    end else begin
      pixel_reg <= rd_en ? mem[rd_addr] : 1'b0;
    end
  end

  assign pixel = pixel_reg;

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: reset, streamed and stalled loads, bounds,
// reset abort, and the mirrored read when SPRITE_MIRROR_EN is defined.
module tb_sprite_loader;

  localparam int NBITS = 87 * 86;
  localparam int B_COL = 100;
  localparam int B_ROW = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        load_done;
  logic        loaded;
  logic [10:0] col;
  logic [10:0] row;
  logic [10:0] b_col;
  logic [10:0] b_row;
  logic        pixel;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  int vectors     = 0;
  int miscompares = 0;

  sprite_loader #(.SPR_W(87), .SPR_H(86)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .busy       (busy),
    .load_done  (load_done),
    .loaded     (loaded),
    .col        (col),
    .row        (row),
    .b_col      (b_col),
    .b_row      (b_row),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror),
`endif
    .pixel      (pixel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
    $display("check %-18s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  // Pattern 1: single 1 at row 37, col 40. Pattern 2: 1s at row 0 col 86 and the last bit.
  function automatic logic pat(input int sel, input int i);
    if (sel == 1) return (i == 87 * 37 + 40);
    return (i == 86) || (i == NBITS - 1);
  endfunction

  task automatic probe(input string tag, input int c, input int r, input logic exp);
    col = 11'(c);
    row = 11'(r);
    tick();
    check(tag, pixel, exp);
  endtask

  task automatic do_load(input int sel, input bit toggle);
    bit early;
    early      = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("busy_in_load", busy, 1'b1);
    check("ready_in_load", bit_ready, 1'b1);
    check("loaded_cleared", loaded, 1'b0);
    for (int i = 0; i < NBITS; i++) begin
      bit_valid = 1'b1;
      bit_in    = pat(sel, i);
      tick();
      if (i < NBITS - 1) begin
        if (load_done) early = 1'b1;
        if (toggle) begin
          bit_valid  = 1'b0;
          bit_in     = 1'b1;
          load_start = (i == 1000);
          tick();
          load_start = 1'b0;
          if (load_done) early = 1'b1;
          if (i == 1000) check("restart_ignored", busy, 1'b1);
        end
      end
    end
    check("done_pulse", load_done, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_not_ready", bit_ready, 1'b0);
    check("no_early_done", early, 1'b0);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tick();
    check("done_one_cycle", load_done, 1'b0);
    check("loaded_set", loaded, 1'b1);
    check("busy_clear", busy, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    col        = '0;
    row        = '0;
    b_col      = '0;
    b_row      = '0;
`ifdef SPRITE_MIRROR_EN
    mirror     = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_pixel", pixel, 1'b0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", bit_ready, 1'b0);
    check("rst_done", load_done, 1'b0);

    // Bits offered in IDLE are not accepted
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (2) tick();
    check("idle_not_ready", bit_ready, 1'b0);
    bit_valid = 1'b0;
    bit_in    = 1'b0;

    b_col = 11'(B_COL);
    b_row = 11'(B_ROW);
    do_load(1, 1'b0);
    probe("p1_hit", 140, 87, 1'b1);
    probe("p1_next_col", 141, 87, 1'b0);
    probe("p1_prev_col", 139, 87, 1'b0);

    // Stalled load with a load_start injected mid-load
    do_load(2, 1'b1);
    probe("p2_last_bit", B_COL + 86, B_ROW + 85, 1'b1);
    probe("p2_row0_col86", B_COL + 86, B_ROW, 1'b1);
    probe("p2_origin", B_COL, B_ROW, 1'b0);
    probe("p2_col_over", B_COL + 87, B_ROW, 1'b0);
    probe("p2_col_wrap", B_COL - 1, B_ROW, 1'b0);
    probe("p2_row_over", B_COL + 86, B_ROW + 86, 1'b0);
    probe("p2_overwritten", 140, 87, 1'b0);
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b1;
    probe("mir_origin", B_COL, B_ROW, 1'b1);
    probe("mir_col86", B_COL + 86, B_ROW, 1'b0);
    probe("mir_last_row", B_COL, B_ROW + 85, 1'b1);
    mirror = 1'b0;
`endif

    // Reset mid-load aborts; stale RAM stays masked
    col        = 11'(B_COL + 86);
    row        = 11'(B_ROW);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("abort_loaded0", loaded, 1'b0);
    tick();
    check("abort_masked", pixel, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      bit_valid = 1'b1;
      bit_in    = pat(1, i);
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_loaded", loaded, 1'b0);
    check("abort_ready", bit_ready, 1'b0);
    check("abort_pixel", pixel, 1'b0);
    bit_valid = 1'b1;
    tick();
    check("abort_no_resume", bit_ready, 1'b0);
    bit_valid = 1'b0;

    do_load(1, 1'b0);
    probe("reload_hit", 140, 87, 1'b1);
    probe("reload_last", B_COL + 86, B_ROW + 85, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 Parameter SPR_W, default 87, sprite width in pixels.
REQ-002 Parameter SPR_H, default 86, sprite height in pixels.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_start  input  1  one-cycle request to begin a new bitmap load.
REQ-006 bit_in  input  1  serial bitmap data: row-major, row 0 first, column 0 first within a row.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 bit_ready  output  1  loader accepts bit_in this cycle.
REQ-009 busy  output  1  load in progress.
REQ-010 load_done  output  1  one-cycle pulse when the final bit is written.
REQ-011 loaded  output  1  a complete bitmap is held.
REQ-012 col, row  input  11  current scan pixel coordinates.
REQ-013 b_col, b_row  input  11  sprite top-left coordinates.
REQ-014 pixel  output  1  registered sprite bit at the scan position.

Function
REQ-015 Storage shall be an SPR_W*SPR_H x 1-bit RAM: one write port (loader), one read port (scan).
REQ-016 FSM states shall be IDLE, LOAD and DONE; reset state is IDLE.
REQ-017 IDLE -> LOAD on load_start: clear wx, wy and loaded.
REQ-018 In LOAD, bit_ready=1. Each cycle with bit_valid=1 writes bit_in to address wy*SPR_W+wx.
REQ-019 wx shall increment per accepted bit. At wx=SPR_W-1, wx wraps to 0 and wy increments.
REQ-020 LOAD -> DONE on the accepted bit at wx=SPR_W-1, wy=SPR_H-1. DONE lasts exactly one cycle, asserts load_done and sets loaded, then returns to IDLE.
REQ-021 busy=1 in LOAD and DONE; bit_ready=0 in IDLE and DONE; bits offered while bit_ready=0 are dropped.
REQ-022 load_start while in LOAD or DONE shall be ignored.
REQ-023 bit_valid=0 in LOAD shall stall without changing the counters; there is no timeout.
REQ-024 Read offsets: dx=col-b_col, dy=row-b_row, 11-bit unsigned; wraps below zero and fails the bound check.
REQ-025 pixel (cycle t+1) = RAM[dy*SPR_W+dx] sampled at t when loaded=1, dx<SPR_W and dy<SPR_H; else 0. Latency is exactly 1 cycle.
REQ-026 A read and a write to the same address in one cycle cannot occur, because loaded=0 throughout LOAD.

Reset
REQ-027 On rst: state=IDLE, wx=wy=0, bit_ready=0, busy=0, load_done=0, loaded=0, pixel=0.
REQ-028 RAM contents are not reset. loaded=0 masks stale data until the next full load.
REQ-029 rst during LOAD aborts the load; a new load_start is required.

Configuration
REQ-030 Macro SPRITE_MIRROR_EN: when defined, adds input mirror (1 bit). With mirror=1, the read column is SPR_W-1-dx (horizontal flip); bound checks are unchanged.
REQ-031 Without SPRITE_MIRROR_EN, the mirror port does not exist and reads are unflipped.

Verification
REQ-032 rst, then col=row=b_col=b_row=0 -> pixel=0, loaded=0, busy=0, bit_ready=0.
REQ-033 load_start, then 7482 bits (1 only at index 87*37+40) with bit_valid=1 every cycle -> load_done pulse 1 cycle after the 7482nd accept; loaded=1; b_col=100, b_row=50, col=140, row=87 -> pixel=1 the next cycle; col=141 -> 0.
REQ-034 Load with bit_valid toggled 1/0 -> counters hold on 0 cycles; load_done after 7482 accepted bits, about 14963 cycles.
REQ-035 After load, col=b_col+87 or col=b_col-1 (wrap) -> pixel=0; row=b_row+85, col=b_col+86 -> last stored bit.
REQ-036 rst asserted after 1000 bits -> busy=0, loaded=0; a second load_start mid-load -> ignored, counters continue.
REQ-037 With SPRITE_MIRROR_EN, mirror=1: col=b_col+0 returns the bit stored at column 86.
